// File: rtl/move_sequencer.sv
// Move controller for the 2048 grid: launches a move wave, waits for all lanes,
// spawns new tiles through the preset path and evaluates game-over.
module move_sequencer #(
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_req,
    input  logic [3:0]  move_dir,
    input  logic        new_game,
    input  logic [3:0]  lane_done,
    input  logic [63:0] board,
    output logic [3:0]  launch,
    output logic        preset_ext,
    output logic [15:0] preset_cell,
    output logic [3:0]  preset_value,
    output logic        busy,
    output logic        moved,
    output logic        error,
    output logic        game_over
);

    localparam int unsigned TimerW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StSettle,
        StCompare,
        StSpawn,
        StCheck
    } state_e;

    state_e             state_q;
    logic [3:0]         dir_q;
    logic [3:0]         done_q;
    logic [63:0]        snap_q;
    logic [TimerW-1:0]  timer_q;
    logic [1:0]         spawns_q;
    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_d;
    logic               preset_ext_q;
    logic [15:0]        preset_cell_q;
    logic [3:0]         preset_value_q;
    logic               moved_q;
    logic               error_q;
    logic               game_over_q;

    logic               dir_ok;
    logic [15:0]        cell_empty;
    logic [3:0]         scan_idx;
    logic               spawn_found;
    logic [15:0]        spawn_cell;
    logic [3:0]         spawn_value;
    logic               has_pair;
    logic               no_moves;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign dir_ok = (move_dir != 4'd0) && ((move_dir & (move_dir - 4'd1)) == 4'd0);

    always_comb begin
        cell_empty = '0;
        for (int k = 0; k < 16; k++) begin
            cell_empty[k] = (board[4*k +: 4] == 4'd0);
        end
    end

    // Spawn target is chosen with the LFSR value the SPAWN cycle will hold (lfsr_d).
    always_comb begin
        spawn_found = 1'b0;
        spawn_cell  = '0;
        scan_idx    = '0;
        for (int i = 0; i < 16; i++) begin
            scan_idx = lfsr_d[3:0] + 4'(i);
            if (!spawn_found && cell_empty[scan_idx]) begin
                spawn_found          = 1'b1;
                spawn_cell[scan_idx] = 1'b1;
            end
        end
        spawn_value = (lfsr_d[7:4] == 4'd0) ? 4'd2 : 4'd1;
    end

    always_comb begin
        has_pair = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (board[4*(4*r+c) +: 4] == board[4*(4*r+c+1) +: 4]) has_pair = 1'b1;
            end
        end
        for (int k = 0; k < 12; k++) begin
            if (board[4*k +: 4] == board[4*(k+4) +: 4]) has_pair = 1'b1;
        end
        no_moves = (cell_empty == 16'd0) && !has_pair;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            dir_q          <= '0;
            done_q         <= '0;
            snap_q         <= '0;
            timer_q        <= '0;
            spawns_q       <= '0;
            lfsr_q         <= LFSR_SEED;
            preset_ext_q   <= 1'b0;
            preset_cell_q  <= '0;
            preset_value_q <= '0;
            moved_q        <= 1'b0;
            error_q        <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            lfsr_q         <= lfsr_d;
            preset_ext_q   <= 1'b0;
            preset_cell_q  <= '0;
            preset_value_q <= '0;
            moved_q        <= 1'b0;
            error_q        <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (new_game) begin
                        game_over_q    <= 1'b0;
                        spawns_q       <= 2'd2;
                        preset_ext_q   <= spawn_found;
                        preset_cell_q  <= spawn_cell;
                        preset_value_q <= spawn_found ? spawn_value : 4'd0;
                        state_q        <= StSpawn;
                    end else if (move_req && dir_ok && !game_over_q) begin
                        dir_q   <= move_dir;
                        snap_q  <= board;
                        state_q <= StLaunch;
                    end
                end
                StLaunch: begin
                    done_q  <= '0;
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // Timeout is committed one cycle early so error is a registered pulse.
                    if (error_q) begin
                        state_q <= StIdle;
                    end else begin
                        done_q  <= done_q | lane_done;
                        timer_q <= timer_q + TimerW'(1);
                        if ((done_q | lane_done) == 4'hF) begin
                            state_q <= StSettle;
                        end else if (timer_q == TimerW'(TIMEOUT - 2)) begin
                            error_q <= 1'b1;
                        end
                    end
                end
                StSettle: begin
                    moved_q <= (board != snap_q);
                    state_q <= StCompare;
                end
                StCompare: begin
                    if (moved_q) begin
                        spawns_q       <= 2'd1;
                        preset_ext_q   <= spawn_found;
                        preset_cell_q  <= spawn_cell;
                        preset_value_q <= spawn_found ? spawn_value : 4'd0;
                        state_q        <= StSpawn;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StSpawn: begin
                    spawns_q <= spawns_q - 2'd1;
                    state_q  <= StCheck;
                end
                StCheck: begin
                    if (spawns_q != 2'd0) begin
                        preset_ext_q   <= spawn_found;
                        preset_cell_q  <= spawn_cell;
                        preset_value_q <= spawn_found ? spawn_value : 4'd0;
                        state_q        <= StSpawn;
                    end else begin
                        if (no_moves) game_over_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign launch       = (state_q == StLaunch) ? dir_q : 4'd0;
    assign busy         = (state_q != StIdle);
    assign preset_ext   = preset_ext_q;
    assign preset_cell  = preset_cell_q;
    assign preset_value = preset_value_q;
    assign moved        = moved_q;
    assign error        = error_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: reset, moves, timeout, spawn, game-over.
module tb_move_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        move_req;
    logic [3:0]  move_dir;
    logic        new_game;
    logic [3:0]  lane_done;
    logic [63:0] brd;
    logic [3:0]  launch;
    logic        preset_ext;
    logic [15:0] preset_cell;
    logic [3:0]  preset_value;
    logic        busy;
    logic        moved;
    logic        error;
    logic        game_over;

    move_sequencer #(
        .TIMEOUT   (64),
        .LFSR_SEED (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .move_req     (move_req),
        .move_dir     (move_dir),
        .new_game     (new_game),
        .lane_done    (lane_done),
        .board        (brd),
        .launch       (launch),
        .preset_ext   (preset_ext),
        .preset_cell  (preset_cell),
        .preset_value (preset_value),
        .busy         (busy),
        .moved        (moved),
        .error        (error),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting left every cycle.
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        seen_moved;
    logic        seen_preset;
    logic [63:0] b_pre;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One cycle: sample on the falling edge; act as the grid for any preset.
    task automatic step();
        @(negedge clk);
        seen_moved  |= moved;
        seen_preset |= preset_ext;
        if (preset_ext === 1'b1) begin
            for (int k = 0; k < 16; k++) begin
                if (preset_cell[k]) brd[4*k +: 4] = preset_value;
            end
        end
    endtask

    function automatic logic [15:0] exp_cell(input logic [63:0] b, input logic [3:0] s);
        logic [15:0] r;
        logic        found;
        logic [3:0]  idx;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = s + 4'(i);
            if (!found && b[4*idx +: 4] == 4'd0) begin
                found  = 1'b1;
                r[idx] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_value(input logic [15:0] l);
        return (l[7:4] == 4'd0) ? 4'd2 : 4'd1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; move_req = 1'b0; move_dir = 4'd0; new_game = 1'b0;
        lane_done = 4'd0; brd = '0; seen_moved = 1'b0; seen_preset = 1'b0;

        // Reset held two cycles
        step(); step();
        chk("rst_launch", 64'(launch), 64'd0);
        chk("rst_pulses", 64'({moved, error, game_over, preset_ext}), 64'd0);
        chk("rst_preset", 64'({preset_cell, preset_value}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        step();
        chk("idle_busy", 64'(busy), 64'd0);

        // No-change move: lanes done 3 cycles after launch
        brd = 64'h1; move_dir = 4'b1000; move_req = 1'b1;
        seen_moved = 1'b0; seen_preset = 1'b0;
        step(); move_req = 1'b0;
        chk("nc_launch", 64'(launch), 64'h8);
        chk("nc_busy", 64'(busy), 64'd1);
        step();
        chk("nc_launch_once", 64'(launch), 64'd0);
        step();
        step(); lane_done = 4'hF;
        step(); lane_done = 4'd0;
        chk("nc_busy_settle", 64'(busy), 64'd1);
        step();
        chk("nc_busy_compare", 64'(busy), 64'd1);
        step();
        chk("nc_idle", 64'(busy), 64'd0);
        chk("nc_no_moved", 64'(seen_moved), 64'd0);
        chk("nc_no_preset", 64'(seen_preset), 64'd0);

        // Changing move: cell 3 slides to cell 0, lanes finish one per cycle
        brd = 64'h1000; move_dir = 4'b0001; move_req = 1'b1;
        step(); move_req = 1'b0;
        chk("ch_launch", 64'(launch), 64'h1);
        step(); lane_done = 4'b0001;
        step(); lane_done = 4'b0010; brd = 64'h1;
        step(); lane_done = 4'b0100;
        step(); lane_done = 4'b1000;
        step(); lane_done = 4'd0;
        chk("ch_settle_no_moved", 64'(moved), 64'd0);
        step();
        chk("ch_moved", 64'(moved), 64'd1);
        chk("ch_compare_no_preset", 64'(preset_ext), 64'd0);
        b_pre = brd;
        step();
        chk("ch_preset_ext", 64'(preset_ext), 64'd1);
        chk("ch_preset_cell", 64'(preset_cell), 64'(exp_cell(b_pre, m_lfsr[3:0])));
        chk("ch_preset_value", 64'(preset_value), 64'(exp_value(m_lfsr)));
        chk("ch_not_cell0", 64'(preset_cell[0]), 64'd0);
        step();
        chk("ch_check_no_preset", 64'(preset_ext), 64'd0);
        chk("ch_check_busy", 64'(busy), 64'd1);
        step();
        chk("ch_idle", 64'(busy), 64'd0);
        chk("ch_no_game_over", 64'(game_over), 64'd0);

        // Timeout: no lanes ever complete
        move_dir = 4'b0100; move_req = 1'b1; seen_preset = 1'b0;
        step(); move_req = 1'b0;
        chk("to_launch", 64'(launch), 64'h4);
        repeat (63) step();
        chk("to_no_error_early", 64'(error), 64'd0);
        step();
        chk("to_error", 64'(error), 64'd1);
        chk("to_error_busy", 64'(busy), 64'd1);
        step();
        chk("to_error_pulse", 64'(error), 64'd0);
        chk("to_idle", 64'(busy), 64'd0);
        chk("to_no_spawn", 64'(seen_preset), 64'd0);
        move_dir = 4'b0010; move_req = 1'b1;
        step(); move_req = 1'b0;
        chk("to_reaccept", 64'(launch), 64'h2);
        step(); lane_done = 4'hF;
        step(); lane_done = 4'd0;
        step();
        step();
        chk("to_reaccept_idle", 64'(busy), 64'd0);

        // Invalid directions are dropped
        move_dir = 4'b0101; move_req = 1'b1;
        step();
        chk("inv_multi", 64'({busy, launch}), 64'd0);
        move_dir = 4'b0000;
        step();
        chk("inv_zero", 64'({busy, launch}), 64'd0);
        move_req = 1'b0;
        step();
        chk("inv_idle", 64'(busy), 64'd0);

        // Game over: checkerboard of 3/4 with cell 5 empty
        for (int k = 0; k < 16; k++) begin
            brd[4*k +: 4] = (((k / 4) + (k % 4)) % 2 == 1) ? 4'd4 : 4'd3;
        end
        brd[23:20] = 4'd0;
        new_game = 1'b1; move_req = 1'b1; move_dir = 4'b0001;
        step(); new_game = 1'b0; move_req = 1'b0;
        chk("go_priority_no_launch", 64'(launch), 64'd0);
        chk("go_spawn1_ext", 64'(preset_ext), 64'd1);
        chk("go_spawn1_cell", 64'(preset_cell), 64'h20);
        chk("go_spawn1_value", 64'(preset_value), 64'(exp_value(m_lfsr)));
        step();
        chk("go_check1", 64'(preset_ext), 64'd0);
        step();
        chk("go_spawn2_skipped", 64'(preset_ext), 64'd0);
        chk("go_spawn2_busy", 64'(busy), 64'd1);
        step();
        step();
        chk("go_set", 64'(game_over), 64'd1);
        chk("go_idle", 64'(busy), 64'd0);
        move_dir = 4'b0001; move_req = 1'b1;
        step(); move_req = 1'b0;
        chk("go_move_ignored", 64'({busy, launch}), 64'd0);
        new_game = 1'b1;
        step(); new_game = 1'b0;
        chk("ng_clears", 64'(game_over), 64'd0);
        chk("ng_busy", 64'(busy), 64'd1);
        repeat (4) step();
        chk("ng_idle", 64'(busy), 64'd0);

        // Reset aborts an accepted new_game with no preset pulse afterwards
        brd[3:0] = 4'd0; new_game = 1'b1; rst = 1'b0;
        step();
        chk("rst_abort_busy", 64'(busy), 64'd0);
        chk("rst_abort_outs", 64'({preset_ext, game_over}), 64'd0);
        rst = 1'b1; new_game = 1'b0;
        step();
        chk("rst_abort_after", 64'({busy, preset_ext}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
